soc_system_gol_pio: RTL

SOC_SYSTEM_GOL_PIO -- requirements
Module: soc_system_gol_pio

---
 rtl/soc_system_gol_pio_if.sv | 23 ++
 rtl/soc_system_gol_pio.sv | 115 +++++++++++
 2 files changed

// File: rtl/soc_system_gol_pio_if.sv
// soc_system_gol_pio_if: Avalon-MM slave bus bundle (word address, 32-bit data, zero wait states).
`default_nettype none
`timescale 1ns/1ps

interface soc_system_gol_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/soc_system_gol_pio.sv
// ==========================================================================
// soc_system_gol_pio: Avalon-MM PIO with edge capture, IRQ and timed pulses
// Revision 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

module soc_system_gol_pio #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               EDGE_TYPE    = 0,
  parameter int               PULSE_CYCLES = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  soc_system_gol_pio_if.slave   bus,
  input  wire logic [WIDTH-1:0] in_port,
  output logic      [WIDTH-1:0] out_port,
  output logic                  irq
);

  logic [WIDTH-1:0] sync1, sync2, sync3;
  logic [WIDTH-1:0] data_out, irq_mask, edge_capture, pulse_bits;
  logic [15:0]      counter;

  logic [WIDTH-1:0] data_out_next, mask_next, ec_next, pulse_next, edges, wdata;
  logic [15:0]      counter_next;
  logic             wr;
  logic [31:0]      rd;
  logic             unused_bits;

  assign wr          = bus.chipselect & ~bus.write_n;
  assign wdata       = bus.writedata[WIDTH-1:0];
  assign unused_bits = ^bus.writedata;

  always_comb begin
    edges = '0;
    case (EDGE_TYPE)
      0:       edges = sync2 & ~sync3;
      1:       edges = ~sync2 & sync3;
      default: edges = sync2 ^ sync3;
    endcase
  end

  always_comb begin
    data_out_next = data_out;
    mask_next     = irq_mask;
    pulse_next    = pulse_bits;
    counter_next  = counter;
    // A fresh edge wins over a simultaneous write-1-to-clear
    ec_next       = (edge_capture & ~((wr && bus.address == 3'd4) ? wdata : '0)) | edges;
    if (wr) begin
      case (bus.address)
        3'd0:    data_out_next = wdata;
        3'd1:    data_out_next = data_out | wdata;
        3'd2:    data_out_next = data_out & ~wdata;
        3'd3:    mask_next     = wdata;
        default: ;
      endcase
    end
    if (wr && bus.address == 3'd5 && wdata != '0) begin
      pulse_next   = pulse_bits | wdata;
      counter_next = 16'(PULSE_CYCLES);
    end else if (counter != 16'd0) begin
      counter_next = counter - 16'd1;
      if (counter == 16'd1) pulse_next = '0;
    end
  end

  always_ff @(posedge clk) sync1 <= in_port;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync2        <= '0;
      sync3        <= '0;
      data_out     <= RESET_VALUE;
      out_port     <= RESET_VALUE;
      irq_mask     <= '0;
      edge_capture <= '0;
      pulse_bits   <= '0;
      counter      <= '0;
    end else begin
      sync2        <= sync1;
      sync3        <= sync2;
      data_out     <= data_out_next;
      out_port     <= data_out_next | pulse_next;
      irq_mask     <= mask_next;
      edge_capture <= ec_next;
      pulse_bits   <= pulse_next;
      counter      <= counter_next;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    rd = '0;
    case (bus.address)
      3'd0:       rd[WIDTH-1:0] = sync2;
      3'd1, 3'd2: rd[WIDTH-1:0] = data_out;
      3'd3:       rd[WIDTH-1:0] = irq_mask;
      3'd4:       rd[WIDTH-1:0] = edge_capture;
      3'd5: begin
        rd[WIDTH-1:0] = pulse_bits;
        if (WIDTH < 32) rd[31] = (counter != 16'd0);
      end
      default:    ;
    endcase
  end

  assign bus.readdata = rd;

endmodule

`default_nettype wire
